tile_matmul_scheduler: RTL and testbench
========================================

Name: tile_matmul_scheduler

Overview:
- Sequences the tiled matrix-multiply engine once both matrices have been received over UART.
- Walks output tiles (ti, tj) and reduction tiles (tk), issuing one tile job at a time to the compute engine over a valid/ready handshake, then waits for that engine's tile_done.
- Handles edge tiles when N is not a multiple of TILE, and signals overall completion to the UART result transmitter.
- Sits between the UART matrix receiver (start = mats_received, mode = mode_byte) and the tile MAC datapath.

Parameters:
- MAX_N, 10, largest supported matrix dimension.
- TILE, 4, tile edge length of the compute engine (2..MAX_N).
- IW, $clog2(MAX_N), width of element index/offset fields (4 at default).
- DW, $clog2(TILE+1), width of tile-dimension fields (3 at default).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  pulse: both matrices loaded (from mats_received)
- mode_byte  in  8  matrix dimension N; only 3 and 10 are legal
- job_valid  out  1  tile job offered
- job_ready  in  1  engine accepts job
- job_row_base  out  IW  ti*TILE
- job_col_base  out  IW  tj*TILE
- job_k_base  out  IW  tk*TILE
- job_rows  out  DW  rows in this tile
- job_cols  out  DW  cols in this tile
- job_kdim  out  DW  reduction length in this tile
- job_first_k  out  1  clear accumulator (tk==0)
- job_last_k  out  1  write back accumulator (tk==last)
- tile_done  in  1  engine finished the accepted job
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse, all tiles complete
- err_mode  out  1  one-cycle pulse, illegal mode_byte

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. On reset, all outputs are 0, all counters are 0, and the FSM goes to IDLE. Reset mid-operation abandons the current job; job_valid drops on the next edge.
- N latch: N is captured from mode_byte on the cycle start is accepted. Later changes to mode_byte are ignored until the next start.
- NT = ceil(N/TILE): NT=1 for N=3, NT=3 for N=10 at TILE=4.
- FSM states:
  - IDLE: start=1 -> CHECK; latch N; busy=1.
  - CHECK: N is 3 or 10 -> ISSUE, with ti=tj=tk=0. Otherwise -> ERR.
  - ERR: err_mode=1 for one cycle; busy=0 -> IDLE.
  - ISSUE: job_valid=1 with all job_* fields stable. job_ready=1 -> WAIT. job_valid must not drop before the handshake.
  - WAIT: job_valid=0. tile_done=1 -> ADVANCE.
  - ADVANCE: loop nest with tk innermost, then tj, then ti.
    - tk<NT-1: tk++, -> ISSUE.
    - Else tk=0. If tj<NT-1: tj++, -> ISSUE.
    - Else tj=0. If ti<NT-1: ti++, -> ISSUE.
    - Else -> DONE.
  - DONE: done=1 for one cycle; busy=0 -> IDLE.
- Job field encoding:
  - job_row_base = ti*TILE; same pattern for column and k bases.
  - job_rows = min(TILE, N - ti*TILE); same pattern for cols and kdim. Computed in IW+1 bits with no wrap.
  - job_first_k = (tk==0); job_last_k = (tk==NT-1). Both are high for NT=1.
- Latency:
  - start -> first job_valid: 2 cycles (CHECK, then ISSUE).
  - tile_done -> next job_valid: 2 cycles (ADVANCE, then ISSUE).
  - Final tile_done -> done: 2 cycles.
- Ignored or edge-case inputs:
  - start while busy is ignored.
  - tile_done outside WAIT is ignored.
  - tile_done in the same cycle as the handshake is not counted.
  - job_ready while job_valid=0 has no effect.
- Job count: exactly NT^3 jobs per run (1 for N=3, 27 for N=10).

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_count[31:0] and stall_count[15:0], cleared on accepted start.
  - cycle_count increments every busy cycle.
  - stall_count increments each ISSUE cycle with job_ready=0.
  - Both counters saturate and hold their value after done.
- When undefined: the ports and logic are absent, and the core behaviour is identical.

Decomposition:
- Package tile_sched_pkg holds:
  - the FSM state enum;
  - the legal mode constants MODE_3=8'd3 and MODE_10=8'd10;
  - the function tile_dim(base, n) returning min(TILE, n-base).
- One natural sub-module, tile_index_counter: the 3-deep nested ti/tj/tk counter with wrap outputs, instantiated once.

Test Plan:
- Mode 3: start with mode_byte=3, job_ready=1, tile_done one cycle after each accept.
  - Required: exactly 1 job, bases 0/0/0, dims 3/3/3, first_k=last_k=1.
  - done pulses 2 cycles after tile_done.
- Mode 10: start with mode_byte=10 (TILE=4).
  - Required: 27 jobs, in order (0,0,0),(0,0,4),(0,0,8),(0,4,0)…
  - k=8 jobs have kdim=2; ti=2 jobs have rows=2.
  - last_k is high on every third job.
- Backpressure: hold job_ready=0 for 5 cycles in ISSUE.
  - Required: job_valid and all fields stable throughout; accept occurs on the ready cycle.
  - With SCHED_PERF_CNT_EN defined, stall_count=5.
- Illegal mode: start with mode_byte=7.
  - Required: err_mode pulse 2 cycles later, no job_valid ever, busy low after the pulse.
- Spurious inputs: start pulsed mid-run, plus tile_done in ISSUE.
  - Required: both ignored; job sequence and count unchanged.
- Reset mid-run: assert reset during WAIT of job 5.
  - Required: next edge gives all outputs 0 and IDLE; a fresh start restarts at (0,0,0).

Source files
------------

// File: rtl/tile_matmul_scheduler_pkg.sv
// Shared types and helpers for the tiled matmul job scheduler.
// Holds the FSM state enum, legal mode constants and tile sizing.
package tile_sched_pkg;

  localparam int MAX_N_DEF = 10;
  localparam int TILE_DEF  = 4;

  localparam logic [7:0] MODE_3  = 8'd3;
  localparam logic [7:0] MODE_10 = 8'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_ERR,
    S_DONE
  } state_t;

  // Extent of a tile starting at base, clipped at n.
  function automatic logic [7:0] tile_dim(
    input logic [7:0] base,
    input logic [7:0] n,
    input logic [7:0] tile
  );
    logic [7:0] rem;
    rem = n - base;
    return (rem < tile) ? rem : tile;
  endfunction

endpackage

// File: rtl/tile_matmul_scheduler_if.sv
// Tile-job handshake between the scheduler and the MAC engine.
// master = scheduler, slave = compute engine.
interface tile_matmul_scheduler_if #(
  parameter int IW = 4,
  parameter int DW = 3
);
  logic          job_valid;
  logic          job_ready;
  logic [IW-1:0] job_row_base;
  logic [IW-1:0] job_col_base;
  logic [IW-1:0] job_k_base;
  logic [DW-1:0] job_rows;
  logic [DW-1:0] job_cols;
  logic [DW-1:0] job_kdim;
  logic          job_first_k;
  logic          job_last_k;
  logic          tile_done;

  modport master (
    output job_valid, job_row_base, job_col_base,
    output job_k_base, job_rows, job_cols, job_kdim,
    output job_first_k, job_last_k,
    input  job_ready, tile_done
  );

  modport slave (
    input  job_valid, job_row_base, job_col_base,
    input  job_k_base, job_rows, job_cols, job_kdim,
    input  job_first_k, job_last_k,
    output job_ready, tile_done
  );
endinterface

// File: rtl/tile_matmul_scheduler_index_counter.sv
// Nested ti/tj/tk tile index counter, tk innermost.
// Exposes per-level wrap flags so the FSM can detect the last job.
module tile_index_counter #(
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  input  logic [IW-1:0] nt,
  output logic [IW-1:0] ti,
  output logic [IW-1:0] tj,
  output logic [IW-1:0] tk,
  output logic          tk_last,
  output logic          tj_last,
  output logic          ti_last,
  output logic          all_last
);
  logic [IW-1:0] top;

  assign top      = nt - IW'(1);
  assign tk_last  = (tk == top);
  assign tj_last  = (tj == top);
  assign ti_last  = (ti == top);
  assign all_last = tk_last & tj_last & ti_last;

  // Advance the loop nest one step; wrap each level at nt-1.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ti <= '0;
      tj <= '0;
      tk <= '0;
    end else if (step) begin
      if (!tk_last) begin
        tk <= tk + IW'(1);
      end else begin
        tk <= '0;
        if (!tj_last) begin
          tj <= tj + IW'(1);
        end else begin
          tj <= '0;
          ti <= ti_last ? '0 : ti + IW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/tile_matmul_scheduler.sv
// Tile job scheduler for the UART matmul engine.
// Optional perf counters enabled by SCHED_PERF_CNT_EN.
module tile_matmul_scheduler
  import tile_sched_pkg::*;
#(
  parameter int MAX_N = MAX_N_DEF,
  parameter int TILE  = TILE_DEF,
  parameter int IW    = $clog2(MAX_N),
  parameter int DW    = $clog2(TILE + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mode_byte,
  tile_matmul_scheduler_if.master job,
  output logic       busy,
  output logic       done,
  output logic       err_mode
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [15:0] stall_count
`endif
);
  state_t        state;
  state_t        state_nxt;
  logic [7:0]    n_q;
  logic [IW-1:0] nt;
  logic [IW-1:0] ti;
  logic [IW-1:0] tj;
  logic [IW-1:0] tk;
  logic [IW-1:0] row_b;
  logic [IW-1:0] col_b;
  logic [IW-1:0] k_b;
  logic          tk_last;
  logic          tj_last;
  logic          ti_last;
  logic          all_last;
  logic          accept_start;
  logic          mode_ok;

  assign accept_start = (state == S_IDLE) && start;
  assign mode_ok = (n_q == MODE_3) || (n_q == MODE_10);
  assign nt = IW'((32'(n_q) + TILE - 1) / TILE);

  assign row_b = IW'(32'(ti) * TILE);
  assign col_b = IW'(32'(tj) * TILE);
  assign k_b   = IW'(32'(tk) * TILE);

  tile_index_counter #(.IW(IW)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == S_CHECK),
    .step     (state == S_ADV),
    .nt       (nt),
    .ti       (ti),
    .tj       (tj),
    .tk       (tk),
    .tk_last  (tk_last),
    .tj_last  (tj_last),
    .ti_last  (ti_last),
    .all_last (all_last)
  );

  // Capture the matrix dimension when a run is accepted.
  always_ff @(posedge clk) begin
    if (reset) n_q <= '0;
    else if (accept_start) n_q <= mode_byte;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CHECK;
      S_CHECK: state_nxt = mode_ok ? S_ISSUE : S_ERR;
      S_ISSUE: if (job.job_ready) state_nxt = S_WAIT;
      S_WAIT:  if (job.tile_done) state_nxt = S_ADV;
      S_ADV:   state_nxt = all_last ? S_DONE : S_ISSUE;
      S_ERR:   state_nxt = S_IDLE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; job fields only driven while offered.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    err_mode         = 1'b0;
    job.job_valid    = 1'b0;
    job.job_row_base = '0;
    job.job_col_base = '0;
    job.job_k_base   = '0;
    job.job_rows     = '0;
    job.job_cols     = '0;
    job.job_kdim     = '0;
    job.job_first_k  = 1'b0;
    job.job_last_k   = 1'b0;
    unique case (state)
      S_CHECK, S_WAIT, S_ADV: busy = 1'b1;
      S_ISSUE: begin
        busy             = 1'b1;
        job.job_valid    = 1'b1;
        job.job_row_base = row_b;
        job.job_col_base = col_b;
        job.job_k_base   = k_b;
        job.job_rows     = DW'(tile_dim(8'(row_b), n_q, 8'(TILE)));
        job.job_cols     = DW'(tile_dim(8'(col_b), n_q, 8'(TILE)));
        job.job_kdim     = DW'(tile_dim(8'(k_b), n_q, 8'(TILE)));
        job.job_first_k  = (tk == '0);
        job.job_last_k   = tk_last;
      end
      S_ERR:   err_mode = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef SCHED_PERF_CNT_EN
  // Saturating busy-cycle and issue-stall counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else if (accept_start) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (busy && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (state == S_ISSUE && !job.job_ready && stall_count != '1)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tile_matmul_scheduler.sv
// Self-checking bench for tile_matmul_scheduler.
// Reference job list built from nested loops over the tile grid.
module tb_tile_matmul_scheduler;
  localparam int TILE = 4;
  localparam int IW   = 4;
  localparam int DW   = 3;

  typedef struct {
    int rb, cb, kb, rows, cols, kdim, fk, lk;
  } job_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] mode_byte;
  logic       busy;
  logic       done;
  logic       err_mode;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  job_t exp_q[$];
  int cyc_exp;
  int stall_exp;

  tile_matmul_scheduler_if #(.IW(IW), .DW(DW)) jif ();

  tile_matmul_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_byte   (mode_byte),
    .job         (jif),
    .busy        (busy),
    .done        (done),
    .err_mode    (err_mode)
`ifdef SCHED_PERF_CNT_EN
    ,
    .cycle_count (cycle_count),
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic job_t cur_job();
    job_t j;
    j.rb   = 32'(jif.job_row_base);
    j.cb   = 32'(jif.job_col_base);
    j.kb   = 32'(jif.job_k_base);
    j.rows = 32'(jif.job_rows);
    j.cols = 32'(jif.job_cols);
    j.kdim = 32'(jif.job_kdim);
    j.fk   = 32'(jif.job_first_k);
    j.lk   = 32'(jif.job_last_k);
    return j;
  endfunction

  task automatic cmp_job(string tag, job_t a, job_t e);
    chk({tag, ".rb"}, a.rb, e.rb);
    chk({tag, ".cb"}, a.cb, e.cb);
    chk({tag, ".kb"}, a.kb, e.kb);
    chk({tag, ".rows"}, a.rows, e.rows);
    chk({tag, ".cols"}, a.cols, e.cols);
    chk({tag, ".kdim"}, a.kdim, e.kdim);
    chk({tag, ".fk"}, a.fk, e.fk);
    chk({tag, ".lk"}, a.lk, e.lk);
  endtask

  task automatic chk_idle(string tag);
    job_t z;
    z = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk({tag, ".valid"}, 32'(jif.job_valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err_mode), 0);
    cmp_job(tag, cur_job(), z);
  endtask

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic build(int n);
    int nt;
    job_t j;
    nt = (n + TILE - 1) / TILE;
    exp_q.delete();
    for (int ti = 0; ti < nt; ti++)
      for (int tj = 0; tj < nt; tj++)
        for (int tk = 0; tk < nt; tk++) begin
          j.rb   = ti * TILE;
          j.cb   = tj * TILE;
          j.kb   = tk * TILE;
          j.rows = min2(TILE, n - ti * TILE);
          j.cols = min2(TILE, n - tj * TILE);
          j.kdim = min2(TILE, n - tk * TILE);
          j.fk   = (tk == 0) ? 1 : 0;
          j.lk   = (tk == nt - 1) ? 1 : 0;
          exp_q.push_back(j);
        end
  endtask

  // One full run: stall < 0 means random stalls; abort_at >= 0
  // asserts reset in WAIT of that job index.
  task automatic run(int n, int stall, bit spur, int abort_at);
    job_t j;
    job_t e;
    int ns;
    int d;
    string t;
    build(n);
    cyc_exp = 1;
    stall_exp = 0;
    start = 1'b1;
    mode_byte = 8'(n);
    step();
    start = 1'b0;
    mode_byte = 8'($urandom);
    chk($sformatf("n%0d.chk_busy", n), 32'(busy), 1);
    chk($sformatf("n%0d.chk_valid", n), 32'(jif.job_valid), 0);
    step();
    for (int i = 0; i < exp_q.size(); i++) begin
      t = $sformatf("n%0d.j%0d", n, i);
      e = exp_q[i];
      j = cur_job();
      chk({t, ".valid"}, 32'(jif.job_valid), 1);
      cmp_job(t, j, e);
      ns = (stall >= 0) ? stall : $urandom_range(0, 2);
      if (spur && ns == 0) ns = 1;
      for (int s = 0; s < ns; s++) begin
        jif.job_ready = 1'b0;
        jif.tile_done = spur;
        step();
        jif.tile_done = 1'b0;
        chk({t, ".hold_valid"}, 32'(jif.job_valid), 1);
        cmp_job({t, ".hold"}, cur_job(), j);
      end
      jif.job_ready = 1'b1;
      jif.tile_done = spur;
      step();
      jif.job_ready = 1'b0;
      jif.tile_done = 1'b0;
      chk({t, ".wait_valid"}, 32'(jif.job_valid), 0);
      chk({t, ".wait_busy"}, 32'(busy), 1);
      if (i == abort_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle({t, ".rst"});
        return;
      end
      d = $urandom_range(0, 3);
      if (spur && d < 2) d = 2;
      for (int k = 0; k < d; k++) begin
        if (spur && k == 0) begin
          start = 1'b1;
          mode_byte = 8'd3;
        end
        step();
        start = 1'b0;
        chk({t, ".dly_valid"}, 32'(jif.job_valid), 0);
        chk({t, ".dly_done"}, 32'(done), 0);
      end
      cyc_exp += ns + 1 + d + 1 + 1;
      stall_exp += ns;
      jif.tile_done = 1'b1;
      step();
      jif.tile_done = 1'b0;
      chk({t, ".adv_valid"}, 32'(jif.job_valid), 0);
      chk({t, ".adv_done"}, 32'(done), 0);
      step();
      if (i == exp_q.size() - 1) begin
        chk({t, ".done"}, 32'(done), 1);
        chk({t, ".done_valid"}, 32'(jif.job_valid), 0);
        step();
        chk({t, ".post_done"}, 32'(done), 0);
        chk({t, ".post_busy"}, 32'(busy), 0);
`ifdef SCHED_PERF_CNT_EN
        chk({t, ".stall_cnt"}, 32'(stall_count), stall_exp);
        chk({t, ".cycle_cnt"}, cycle_count, cyc_exp);
`endif
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode_byte = 8'd0;
    jif.job_ready = 1'b0;
    jif.tile_done = 1'b0;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;
    step();
    chk_idle("idle");

    run(3, -1, 1'b0, -1);
    run(10, -1, 1'b0, -1);
    run(3, 5, 1'b0, -1);
`ifdef SCHED_PERF_CNT_EN
    chk("bp.stall5", 32'(stall_count), 5);
`endif

    start = 1'b1;
    mode_byte = 8'd7;
    step();
    start = 1'b0;
    jif.job_ready = 1'b1;
    chk("ill.err0", 32'(err_mode), 0);
    chk("ill.valid0", 32'(jif.job_valid), 0);
    step();
    chk("ill.err1", 32'(err_mode), 1);
    chk("ill.valid1", 32'(jif.job_valid), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ill.err_after", 32'(err_mode), 0);
      chk("ill.busy_after", 32'(busy), 0);
      chk("ill.valid_after", 32'(jif.job_valid), 0);
    end
    jif.job_ready = 1'b0;

    run(10, -1, 1'b1, -1);
    run(10, -1, 1'b0, 4);
    run(10, -1, 1'b0, -1);
    run(3, -1, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
